// File: rtl/fftram_pkg.sv
// Shared constants, requester indices and arbiter state encoding for the
// FFT magnitude RAM read-port arbiter.
package fftram_pkg;

  localparam int FFT_AW    = 10;
  localparam int FFT_DW    = 28;
  localparam int FFT_NBINS = 1024;

  localparam int REQ_DETECT = 0;
  localparam int REQ_HOST   = 1;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins; the winner is reported one-hot.
module rr_pick
  import fftram_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic found;

  // Outer loop walks the search order ptr, ptr+1, ...; inner loop keeps
  // every bit select a constant index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fftram_rd_arbiter.sv
// Read-port arbiter for the FFT magnitude RAM: round-robin grant, lock,
// burst preemption and latency-aligned rvalid tags.
// Optional idle-lock timeout is built when FFTRAM_ARB_TIMEOUT_EN is defined.
module fftram_rd_arbiter
  import fftram_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int AW           = FFT_AW,
  parameter int DW           = FFT_DW,
  parameter int RD_LAT       = 1,
  parameter int MAX_BURST    = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        ramaddr,
  input  logic [DW-1:0]        ramq,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      rvalid,
  output logic                 busy
`ifdef FFTRAM_ARB_TIMEOUT_EN
  ,
  output logic                 lock_timeout
`endif
);

  // Handshake: requester i has a read accepted in every cycle where
  // req[i] & gnt[i]; the address is taken from addr slice i in that cycle,
  // and the data returns RD_LAT+1 cycles later with rvalid[i] high.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_t       state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [PW-1:0]    own, own_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [BW-1:0]    burst, burst_n;
  logic [AW-1:0]    ramaddr_n;
  logic [NREQ-1:0]  tag_in;
  logic [NREQ-1:0]  tag_line [0:RD_LAT];
  logic [NREQ-1:0]  win;
  logic             accept;
  logic             other_req;
  logic             preempt;
  logic             release_now;
  logic             timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    own_n       = own;
    ptr_n       = ptr;
    burst_n     = burst;
    ramaddr_n   = ramaddr;
    tag_in      = '0;
    accept      = 1'b0;
    preempt     = 1'b0;
    release_now = 1'b0;
    other_req   = |(req & ~gnt);
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_n = ARB_GRANT;
          gnt_n   = win;
          for (int i = 0; i < NREQ; i++) begin
            if (win[i]) own_n = PW'(i);
          end
        end
      end
      ARB_GRANT: begin
        accept = req[own] & gnt[own];
        if (accept) begin
          ramaddr_n = addr[own*AW +: AW];
          tag_in    = gnt;
          if (burst != BURST_MAX) burst_n = burst + 1'b1;
        end
        // Judged on the post-increment count so the MAX_BURST-th read is
        // the last one accepted before handover.
        preempt = (MAX_BURST != 0) && !lock[own] && (burst_n == BURST_MAX)
                  && other_req;
        release_now = (!req[own] && !lock[own]) || preempt || timeout_hit;
        if (release_now) begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
          ptr_n   = PW'(wrap_inc(int'(own), NREQ));
          burst_n = '0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      own     <= '0;
      ptr     <= '0;
      burst   <= '0;
      ramaddr <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_line[i] <= '0;
    end else begin
      gnt         <= gnt_n;
      own         <= own_n;
      ptr         <= ptr_n;
      burst       <= burst_n;
      ramaddr     <= ramaddr_n;
      tag_line[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) tag_line[i] <= tag_line[i-1];
    end
  end

`ifdef FFTRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  logic [TW-1:0] tcnt, tcnt_n;
  logic          lock_idle;

  // A locked owner that is not reading: the only situation the timer watches.
  assign lock_idle   = (state == ARB_GRANT) && lock[own] && !req[own];
  assign timeout_hit = lock_idle && (tcnt == TIMEOUT_LAST);

  always_comb begin
    tcnt_n = '0;
    if (lock_idle && !accept && !release_now) tcnt_n = tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt         <= '0;
      lock_timeout <= 1'b0;
    end else begin
      tcnt         <= tcnt_n;
      lock_timeout <= timeout_hit;
    end
  end
`else
  logic unused_lock_timeout_cfg;
  assign unused_lock_timeout_cfg = (LOCK_TIMEOUT > 0);
  assign timeout_hit = 1'b0;
`endif

  assign rvalid = tag_line[RD_LAT];
  assign rdata  = ramq;
  assign busy   = |gnt;

endmodule

// File: doc/fftram_rd_arbiter.md
# fftram_rd_arbiter

Shares the single read port of the 1024×28 FFT magnitude RAM between several read requesters: the peak-bin detector scan, host readout, and any later consumers. It sits between the requesters and the RAM read address/q pins. It provides round-robin arbitration, grant locking for full-frame scans, burst-length preemption, and per-requester read-data valid tagging aligned to the RAM read latency.

## Interface
- NREQ, 2: number of requesters; index 0 is the peak detector, index 1 is host readout.
- AW, 10: RAM address width.
- DW, 28: RAM data width.
- RD_LAT, 1: cycles from the `ramaddr` register to valid `ramq`.
- MAX_BURST, 16: accepted reads before an unlocked grantee is preempted; 0 disables preemption.
- LOCK_TIMEOUT, 4096: idle-lock cycle limit, used only with the timeout macro.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester read request; one read per cycle while held and granted.
- lock  in  NREQ  grantee holds its grant while high, even with req low.
- addr  in  NREQ*AW  flattened per-requester read address; slice i belongs to requester i.
- gnt  out  NREQ  registered one-hot grant.
- ramaddr  out  AW  registered RAM read address.
- ramq  in  DW  RAM read data.
- rdata  out  DW  equal to `ramq`; combinational pass-through.
- rvalid  out  NREQ  one-hot; rdata belongs to requester i.
- busy  out  1  any grant active.
- lock_timeout  out  1  one-cycle pulse; exists only with the macro.

## Operation
- Two states:
  - IDLE: gnt=0. If any req is high, the round-robin picker selects a winner starting at `ptr`. The winner's gnt is set next cycle and the state moves to GRANT.
  - GRANT (owner g): a read is accepted in each cycle where req[g]&gnt[g]. On acceptance, `ramaddr` <= addr[g] and the burst counter increments, saturating at MAX_BURST.
- Release:
  - Voluntary: in GRANT, req[g]=0 and lock[g]=0. Next cycle: gnt=0, IDLE, ptr=(g+1) mod NREQ, burst counter cleared.
  - Preemption: lock[g]=0, counter==MAX_BURST (MAX_BURST≠0), and any req[j], j≠g, high. Release is identical to voluntary release. The MAX_BURST-th read is still accepted.
- Locked grants are never preempted. A locked grantee with req low issues no reads and keeps gnt.
- Requests from non-grantees are ignored; there is no queueing.
- Read tagging: a delay line of depth RD_LAT+1 carries the owner of each accepted read. rvalid is that tag at the end of the line.
- Reset values: gnt=0, ramaddr=0, rvalid=0 (entire delay line cleared), busy=0, ptr=0, counter=0, state IDLE, lock_timeout=0.
- Reset mid-burst drops in-flight reads. No rvalid may appear after reset deasserts until new reads are accepted.
- Boundaries:
  - addr wraps naturally at 2^AW; the arbiter does no address checking.
  - If all req fall in the same cycle as preemption, the release is voluntary with no other winner, and the state goes IDLE.

## Timing
- Request to grant: req rises in IDLE at cycle N → gnt high at N+1. The first read can be accepted at N+1.
- Acceptance at cycle A → ramaddr valid at A+1 → rvalid and rdata valid at A+1+RD_LAT (A+2 by default).
- Back-to-back: one read per cycle with no bubbles while granted.
- Handover costs one idle cycle:
  - release condition seen at N;
  - gnt=0 at N+1 (IDLE arbitrates);
  - new gnt at N+2.
- rvalid for the outgoing owner's last reads still emerges after handover. Tags are never mixed.

## Configuration
- `FFTRAM_ARB_TIMEOUT_EN` defined: adds the `lock_timeout` port and a counter.
  - The counter counts consecutive GRANT cycles with lock[g]=1 and req[g]=0.
  - At LOCK_TIMEOUT it forces a release as a voluntary release and pulses `lock_timeout` for one cycle.
  - The counter clears on any accepted read or release.
- Undefined: no port and no counter; a lock is held indefinitely.

## Structure
- Package `fftram_pkg`: FFT_AW=10, FFT_DW=28, FFT_NBINS=1024, requester index constants REQ_DETECT=0 and REQ_HOST=1, and the arbiter state enum.
- Sub-module `rr_pick`: combinational round-robin picker with inputs req and ptr and a one-hot winner output. The FSM, burst counter, and tag delay line stay in the top module.

## Test plan
- After reset, req=2'b11 asserted together → gnt=2'b01 at the next edge; requester 1 is granted only after requester 0 releases, with one idle cycle between grants.
- Requester 0 locks and scans addr 0..1023. Requester 1 requests addr 0x0CC at scan read 100 → gnt[1] only after lock[0] falls. rdata=0xDDDD is tagged by rvalid=2'b10.
- A single accepted read at cycle A → rvalid at exactly A+2 (RD_LAT=1). Repeat with RD_LAT=2 → A+3.
- MAX_BURST=16, both requesters continuously requesting and unlocked → grants alternate every 16 accepted reads, and each rvalid count equals 16 per grant.
- Reset asserted mid-burst with reads in flight → gnt=0, ramaddr=0, and rvalid=0 from the next edge, with no stale rvalid afterwards.
- With `FFTRAM_ARB_TIMEOUT_EN` and LOCK_TIMEOUT=8: lock held with req low → lock_timeout pulses once after 8 cycles, gnt drops, and the other requester is granted.
